// File: rtl/el2_ifu_ic_tag_ctl_if.sv
// Request/response bundle for the I-cache tag controller: lookup, fill,
// invalidate-all, replacement and debug tag read.
interface el2_ifu_ic_tag_ctl_if #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 128,
    parameter int INDEX_LO = 6
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - INDEX_LO - IDX_W;

    logic                  ecc_disable;
    logic                  rd_en;
    logic [31:INDEX_LO]    rw_addr;
    logic [NUM_WAYS-1:0]   wr_en;
    logic                  wr_valid;
    logic [NUM_WAYS-1:0]   rd_hit;
    logic                  rd_hit_any;
    logic                  tag_perr;
    logic [NUM_WAYS-1:0]   repl_way;
    logic                  inv_all_req;
    logic                  inv_busy;
    logic                  inv_done;
    logic                  dbg_rd_en;
    logic [IDX_W-1:0]      dbg_index;
    logic [NUM_WAYS-1:0]   dbg_way;
    logic [TAG_W+1:0]      dbg_rd_data;
    logic                  dbg_rd_valid;

    modport master (
        output ecc_disable, rd_en, rw_addr, wr_en, wr_valid, inv_all_req,
               dbg_rd_en, dbg_index, dbg_way,
        input  rd_hit, rd_hit_any, tag_perr, repl_way, inv_busy, inv_done,
               dbg_rd_data, dbg_rd_valid
    );

    modport slave (
        input  ecc_disable, rd_en, rw_addr, wr_en, wr_valid, inv_all_req,
               dbg_rd_en, dbg_index, dbg_way,
        output rd_hit, rd_hit_any, tag_perr, repl_way, inv_busy, inv_done,
               dbg_rd_data, dbg_rd_valid
    );
endinterface

// File: rtl/el2_ifu_ic_tag_ctl.sv
// Parametrised I-cache tag controller: flop tag store, registered lookup with parity,
// debug read, invalidate-all walker, victim select. EL2_IC_TAG_PLRU_EN selects tree PLRU.
module el2_ifu_ic_tag_ctl #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 128,
    parameter int INDEX_LO = 6
) (
    input logic                 clk,
    input logic                 rst_l,
    el2_ifu_ic_tag_ctl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - INDEX_LO - IDX_W;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {INV_IDLE, INV_WALK, INV_DONE} inv_state_t;

    logic [IDX_W-1:0]    idx;
    logic [TAG_W-1:0]    tag;
    logic                wr_go;
    logic                rd_go;
    logic                walk_clr;
    inv_state_t          inv_state;
    logic [IDX_W-1:0]    inv_cnt;
    logic                inv_busy_q;
    logic                inv_done_q;
    logic [NUM_WAYS-1:0] look_hit;
    logic [NUM_WAYS-1:0] look_perr;
    logic [NUM_WAYS-1:0] set_vld;
    logic [TAG_W+1:0]    dbg_ent [NUM_WAYS];
    logic [TAG_W+1:0]    dbg_sel;
    logic [TAG_W+1:0]    dbg_data_q;
    logic                dbg_valid_q;
    logic                rd_vld_q;
    logic [NUM_WAYS-1:0] hit_raw_q;
    logic [NUM_WAYS-1:0] perr_raw_q;
    logic                multi_hit;
    logic                tag_perr;
    logic [NUM_WAYS-1:0] rd_hit;
    logic                rd_hit_any;
    logic [NUM_WAYS-1:0] lowest_inv;
    logic [NUM_WAYS-1:0] policy_way;

    assign idx      = bus.rw_addr[INDEX_LO+IDX_W-1:INDEX_LO];
    assign tag      = bus.rw_addr[31:INDEX_LO+IDX_W];
    assign wr_go    = (bus.wr_en != '0) && !inv_busy_q;
    assign rd_go    = bus.rd_en && !inv_busy_q;
    assign walk_clr = (inv_state == INV_WALK);

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
        logic [NUM_SETS-1:0] vld_q;
        logic [NUM_SETS-1:0] par_q;
        logic [TAG_W-1:0]    tag_mem [NUM_SETS];

        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                vld_q <= '0;
            end else if (walk_clr) begin
                vld_q[inv_cnt] <= 1'b0;
            end else if (wr_go && bus.wr_en[gi]) begin
                vld_q[idx] <= bus.wr_valid;
            end
        end

        // Tag and parity carry no reset; only the valid bit qualifies them.
        always_ff @(posedge clk) begin
            if (wr_go && bus.wr_en[gi]) begin
                tag_mem[idx] <= tag;
                par_q[idx]   <= ^tag;
            end
        end

        assign look_hit[gi]  = vld_q[idx] && (tag_mem[idx] == tag) && (par_q[idx] == ^tag_mem[idx]);
        assign look_perr[gi] = vld_q[idx] && (par_q[idx] != ^tag_mem[idx]);
        assign set_vld[gi]   = vld_q[idx];
        assign dbg_ent[gi]   = {vld_q[bus.dbg_index], par_q[bus.dbg_index], tag_mem[bus.dbg_index]};
    end

    // Compare happens in the request cycle so a same-cycle fill is not observed.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_vld_q   <= 1'b0;
            hit_raw_q  <= '0;
            perr_raw_q <= '0;
        end else begin
            rd_vld_q <= rd_go;
            if (bus.rd_en) begin
                hit_raw_q  <= look_hit;
                perr_raw_q <= look_perr;
            end
        end
    end

    assign multi_hit  = |(hit_raw_q & (hit_raw_q - {{(NUM_WAYS-1){1'b0}}, 1'b1}));
    assign tag_perr   = rd_vld_q && !bus.ecc_disable && ((|perr_raw_q) || multi_hit);
    assign rd_hit     = (rd_vld_q && !tag_perr) ? hit_raw_q : '0;
    assign rd_hit_any = |rd_hit;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            inv_state  <= INV_IDLE;
            inv_cnt    <= '0;
            inv_busy_q <= 1'b0;
            inv_done_q <= 1'b0;
        end else begin
            inv_done_q <= 1'b0;
            case (inv_state)
                INV_IDLE: begin
                    if (bus.inv_all_req) begin
                        inv_state  <= INV_WALK;
                        inv_cnt    <= '0;
                        inv_busy_q <= 1'b1;
                    end
                end
                INV_WALK: begin
                    inv_cnt <= inv_cnt + IDX_W'(1);
                    if (inv_cnt == IDX_W'(NUM_SETS - 1)) begin
                        inv_state <= INV_DONE;
                    end
                end
                INV_DONE: begin
                    inv_state  <= INV_IDLE;
                    inv_busy_q <= 1'b0;
                    inv_done_q <= 1'b1;
                end
                default: inv_state <= INV_IDLE;
            endcase
        end
    end

    always_comb begin
        dbg_sel = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (bus.dbg_way[w]) begin
                dbg_sel = dbg_sel | dbg_ent[w];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            dbg_data_q  <= '0;
            dbg_valid_q <= 1'b0;
        end else begin
            dbg_valid_q <= bus.dbg_rd_en;
            if (bus.dbg_rd_en) begin
                dbg_data_q <= dbg_sel;
            end
        end
    end

`ifdef EL2_IC_TAG_PLRU_EN
    // Tree node n (1-based heap order): 0 steers the victim left, 1 steers it right.
    logic [NUM_WAYS-1:1] plru_q [NUM_SETS];
    logic [IDX_W-1:0]    hit_idx_q;

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-1:1] t);
        int n;
        n = 1;
        for (int l = 0; l < WAY_W; l++) begin
            n = 2 * n + (t[n] ? 1 : 0);
        end
        return WAY_W'(n - NUM_WAYS);
    endfunction

    function automatic logic [NUM_WAYS-1:1] plru_touch(input logic [NUM_WAYS-1:1] t,
                                                       input logic [WAY_W-1:0]    w);
        logic [NUM_WAYS-1:1] r;
        int leaf;
        int n;
        r    = t;
        leaf = NUM_WAYS + int'(w);
        for (int l = 0; l < WAY_W; l++) begin
            n    = leaf >> (WAY_W - l);
            r[n] = (((leaf >> (WAY_W - l - 1)) & 1) == 0);
        end
        return r;
    endfunction

    function automatic logic [WAY_W-1:0] first_way(input logic [NUM_WAYS-1:0] v);
        logic [WAY_W-1:0] r;
        r = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (v[w]) r = WAY_W'(w);
        end
        return r;
    endfunction

    // The fill update is issued last so it overrides a hit to the same set.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            hit_idx_q <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            if (bus.rd_en) begin
                hit_idx_q <= idx;
            end
            if (rd_hit_any) begin
                plru_q[hit_idx_q] <= plru_touch(plru_q[hit_idx_q], first_way(rd_hit));
            end
            if (wr_go) begin
                plru_q[idx] <= plru_touch(plru_q[idx], first_way(bus.wr_en));
            end
        end
    end

    assign policy_way = NUM_WAYS'(1) << plru_victim(plru_q[idx]);
`else
    logic [WAY_W-1:0] rr_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rr_q <= '0;
        end else if (wr_go) begin
            rr_q <= rr_q + WAY_W'(1);
        end
    end

    assign policy_way = NUM_WAYS'(1) << rr_q;
`endif

    assign lowest_inv = ~set_vld & (set_vld + {{(NUM_WAYS-1){1'b0}}, 1'b1});

    assign bus.repl_way     = (|lowest_inv) ? lowest_inv : policy_way;
    assign bus.rd_hit       = rd_hit;
    assign bus.rd_hit_any   = rd_hit_any;
    assign bus.tag_perr     = tag_perr;
    assign bus.inv_busy     = inv_busy_q;
    assign bus.inv_done     = inv_done_q;
    assign bus.dbg_rd_data  = dbg_data_q;
    assign bus.dbg_rd_valid = dbg_valid_q;
endmodule

// File: tb/tb_el2_ifu_ic_tag_ctl.sv
// Directed bench for el2_ifu_ic_tag_ctl (4 ways, 128 sets, 19-bit tags).
module tb_el2_ifu_ic_tag_ctl;
    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 128;
    localparam int INDEX_LO = 6;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   fills = 0;

    el2_ifu_ic_tag_ctl_if #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS), .INDEX_LO(INDEX_LO)) bus ();

    el2_ifu_ic_tag_ctl #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS), .INDEX_LO(INDEX_LO)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int s, input logic [3:0] ways, input logic [18:0] tg, input logic v);
        bus.rw_addr  = {tg, 7'(s)};
        bus.wr_en    = ways;
        bus.wr_valid = v;
        tick();
        bus.wr_en = '0;
        fills++;
    endtask

    task automatic lookup(input int s, input logic [18:0] tg);
        bus.rw_addr = {tg, 7'(s)};
        bus.rd_en   = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic point(input int s);
        bus.rw_addr = {19'h0, 7'(s)};
        #1;
    endtask

    task automatic dbg_read(input int s, input logic [3:0] way);
        bus.dbg_rd_en = 1'b1;
        bus.dbg_index = 7'(s);
        bus.dbg_way   = way;
        tick();
        bus.dbg_rd_en = 1'b0;
    endtask

    logic [NUM_SETS-1:0] par_save;
    int busy_cnt;
    int done_cnt;
    int done_while_busy;

    initial begin
        bus.ecc_disable = 1'b0;
        bus.rd_en       = 1'b0;
        bus.rw_addr     = '0;
        bus.wr_en       = '0;
        bus.wr_valid    = 1'b0;
        bus.inv_all_req = 1'b0;
        bus.dbg_rd_en   = 1'b0;
        bus.dbg_index   = '0;
        bus.dbg_way     = '0;

        repeat (3) tick();
        chk("rst_rd_hit", 32'(bus.rd_hit), 32'h0);
        chk("rst_hit_any", 32'(bus.rd_hit_any), 32'h0);
        chk("rst_perr", 32'(bus.tag_perr), 32'h0);
        chk("rst_busy", 32'(bus.inv_busy), 32'h0);
        chk("rst_done", 32'(bus.inv_done), 32'h0);
        chk("rst_dbg_valid", 32'(bus.dbg_rd_valid), 32'h0);
        chk("rst_dbg_data", 32'(bus.dbg_rd_data), 32'h0);
        rst_l = 1'b1;
        tick();

        fill(5, 4'b0100, 19'h1234, 1'b1);
        lookup(5, 19'h1234);
        chk("hit_rd_hit", 32'(bus.rd_hit), 32'h4);
        chk("hit_any", 32'(bus.rd_hit_any), 32'h1);
        chk("hit_perr", 32'(bus.tag_perr), 32'h0);
        lookup(5, 19'h1235);
        chk("miss_rd_hit", 32'(bus.rd_hit), 32'h0);
        chk("miss_perr", 32'(bus.tag_perr), 32'h0);

        par_save = dut.g_way[2].par_q;
        force dut.g_way[2].par_q = par_save ^ (128'd1 << 5);
        lookup(5, 19'h1234);
        chk("par_perr", 32'(bus.tag_perr), 32'h1);
        chk("par_rd_hit", 32'(bus.rd_hit), 32'h0);
        bus.ecc_disable = 1'b1;
        lookup(5, 19'h1234);
        chk("par_ecc_off_perr", 32'(bus.tag_perr), 32'h0);
        chk("par_ecc_off_hit", 32'(bus.rd_hit), 32'h0);
        bus.ecc_disable = 1'b0;
        release dut.g_way[2].par_q;
        fill(5, 4'b0100, 19'h1234, 1'b1);
        lookup(5, 19'h1234);
        chk("refill_hit", 32'(bus.rd_hit), 32'h4);

        fill(9, 4'b0011, 19'h55, 1'b1);
        lookup(9, 19'h55);
        chk("multi_perr", 32'(bus.tag_perr), 32'h1);
        chk("multi_rd_hit", 32'(bus.rd_hit), 32'h0);
        chk("multi_any", 32'(bus.rd_hit_any), 32'h0);

        fill(7, 4'b1000, 19'hABC, 1'b1);
        dbg_read(7, 4'b1000);
        chk("dbg_valid", 32'(bus.dbg_rd_valid), 32'h1);
        chk("dbg_data_7_3", 32'(bus.dbg_rd_data), 32'h180ABC);
        tick();
        chk("dbg_valid_drop", 32'(bus.dbg_rd_valid), 32'h0);
        dbg_read(5, 4'b0100);
        chk("dbg_data_5_2", 32'(bus.dbg_rd_data), 32'h181234);
        dbg_read(7, 4'b0000);
        chk("dbg_no_way", 32'(bus.dbg_rd_data), 32'h0);

        point(3);
        chk("repl_empty", 32'(bus.repl_way), 32'h1);
        fill(3, 4'b0001, 19'h10, 1'b1);
        chk("repl_inv1", 32'(bus.repl_way), 32'h2);
        fill(3, 4'b0010, 19'h11, 1'b1);
        chk("repl_inv2", 32'(bus.repl_way), 32'h4);
        fill(3, 4'b0100, 19'h12, 1'b1);
        chk("repl_inv3", 32'(bus.repl_way), 32'h8);
        fill(3, 4'b1000, 19'h13, 1'b1);
`ifdef EL2_IC_TAG_PLRU_EN
        chk("repl_plru_full", 32'(bus.repl_way), 32'h1);
`else
        chk("repl_rr_0", 32'(bus.repl_way), 32'(4'b0001 << (fills % 4)));
`endif
        lookup(3, 19'h10);
        chk("repl_hit_w0", 32'(bus.rd_hit), 32'h1);
        tick();
        point(3);
`ifdef EL2_IC_TAG_PLRU_EN
        chk("repl_plru_after_hit", 32'(bus.repl_way), 32'h4);
`else
        chk("repl_rr_hit_no_adv", 32'(bus.repl_way), 32'(4'b0001 << (fills % 4)));
`endif
        for (int i = 0; i < 3; i++) begin
            fill(20, 4'(1 << i), 19'h20, 1'b1);
            point(3);
`ifdef EL2_IC_TAG_PLRU_EN
            chk("repl_plru_other_set", 32'(bus.repl_way), 32'h4);
`else
            chk("repl_rr_step", 32'(bus.repl_way), 32'(4'b0001 << (fills % 4)));
`endif
        end

        bus.rw_addr  = {19'h42, 7'd40};
        bus.rd_en    = 1'b1;
        bus.wr_en    = 4'b0001;
        bus.wr_valid = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        bus.wr_en = '0;
        fills++;
        chk("rw_same_cycle_old", 32'(bus.rd_hit), 32'h0);
        lookup(40, 19'h42);
        chk("rw_same_cycle_new", 32'(bus.rd_hit), 32'h1);
        fill(41, 4'b0001, 19'h43, 1'b0);
        lookup(41, 19'h43);
        chk("fill_invalid_miss", 32'(bus.rd_hit), 32'h0);

        for (int s = 0; s < NUM_SETS; s++) fill(s, 4'b1111, 19'h77, 1'b1);
        bus.inv_all_req = 1'b1;
        tick();
        bus.inv_all_req = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        done_while_busy = 0;
        for (int c = 0; c < 300; c++) begin
            if (bus.inv_busy) busy_cnt++;
            if (bus.inv_done) done_cnt++;
            if (bus.inv_done && bus.inv_busy) done_while_busy++;
            if (c == 40) begin
                bus.rw_addr  = {19'h99, 7'd10};
                bus.wr_en    = 4'b0001;
                bus.wr_valid = 1'b1;
            end
            if (c == 41) bus.wr_en = '0;
            if (c == 50) begin
                bus.rw_addr = {19'h77, 7'd120};
                bus.rd_en   = 1'b1;
            end
            if (c == 51) begin
                bus.rd_en = 1'b0;
                chk("walk_rd_hit", 32'(bus.rd_hit), 32'h0);
                chk("walk_rd_perr", 32'(bus.tag_perr), 32'h0);
            end
            bus.inv_all_req = (c == 60);
            tick();
        end
        bus.inv_all_req = 1'b0;
        chk("inv_busy_cycles", 32'(busy_cnt), 32'(NUM_SETS + 1));
        chk("inv_done_pulses", 32'(done_cnt), 32'h1);
        chk("inv_done_overlap", 32'(done_while_busy), 32'h0);
        lookup(10, 19'h99);
        chk("walk_fill_dropped", 32'(bus.rd_hit), 32'h0);
        lookup(0, 19'h77);
        chk("post_inv_set0", 32'(bus.rd_hit_any), 32'h0);
        lookup(120, 19'h77);
        chk("post_inv_set120_hit", 32'(bus.rd_hit_any), 32'h0);
        chk("post_inv_set120_perr", 32'(bus.tag_perr), 32'h0);
        lookup(127, 19'h77);
        chk("post_inv_set127", 32'(bus.rd_hit_any), 32'h0);
        point(3);
        chk("post_inv_repl", 32'(bus.repl_way), 32'h1);

        fill(50, 4'b0010, 19'h60, 1'b1);
        bus.inv_all_req = 1'b1;
        tick();
        bus.inv_all_req = 1'b0;
        repeat (20) tick();
        chk("midwalk_busy", 32'(bus.inv_busy), 32'h1);
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        tick();
        chk("midwalk_rst_busy", 32'(bus.inv_busy), 32'h0);
        chk("midwalk_rst_done", 32'(bus.inv_done), 32'h0);
        lookup(50, 19'h60);
        chk("midwalk_rst_miss", 32'(bus.rd_hit), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
